// File: rtl/uart_pkg.sv
// Shared types and constants for the shared 8N1 UART transmitter (uart_tx_sched).
// Latency: n/a (declarations only). Backpressure: n/a.
// Build option: UART_TX_PARITY_EN adds an even-parity bit, giving an 11-bit frame.
package uart_pkg;

    // Transmit FSM states (explicit encoding so waveforms stay readable across builds)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Width of the bit-period counter
    localparam int CNT_W = 16;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Terminal count of the bit-period counter: one bit lasts (result + 1) clocks
    function automatic logic [CNT_W-1:0] calc_divisor(input int high_clk, input int baud_clk);
        int v;
        v = high_clk / baud_clk - 1;
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-period timer: pulses o_tick for one clock every DIVISOR+1 enabled clocks.
// Latency: tick is combinational from the counter; restart clears it on the next edge.
// Backpressure: i_enable=0 freezes the count; i_restart overrides to realign a new frame.
module uart_bit_tick
    import uart_pkg::*;
#(
    parameter logic [CNT_W-1:0] DIVISOR = 16'd433
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Tick only on an enabled cycle so a frozen count never advances the FSM
    assign o_tick = i_enable && (r_cnt == DIVISOR);

    // Free-running modulo-(DIVISOR+1) counter, realigned to zero when a frame is accepted
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == DIVISOR) ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin shares one 8N1 UART TX line between N_REQ byte requesters (optional parity: UART_TX_PARITY_EN).
// Latency: tx_out drops to the start bit the cycle after accept; frame = FRAME_BITS*(DIVISOR+1) cycles.
// Backpressure: req_ready pulses only in IDLE with enable=1; enable=0 freezes the frame in place.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int HIGH_CLK = 50_000_000,
    parameter int BAUD_CLK = 115_200,
    parameter int N_REQ    = 2
) (
    input  logic               high_clk_in,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_out,
    output logic               busy,
    output logic [1:0]         grant_id
);

    localparam logic [CNT_W-1:0] DIVISOR = calc_divisor(HIGH_CLK, BAUD_CLK);

    state_t      r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_tx;
    logic [1:0]  r_grant;
    logic [1:0]  r_last_grant;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic        w_tick;
    logic        w_found;
    logic        w_accept;
    logic [1:0]  w_winner;
    logic [1:0]  w_idx;
    logic [3:0]  w_valid4;
    logic [31:0] w_data32;
    logic [7:0]  w_byte;

    // Pad the request vectors to the 4-requester maximum so 2-bit indices are always in range
    assign w_valid4 = 4'(req_valid);
    assign w_data32 = 32'(req_data);
    assign w_byte   = w_data32[8*w_winner +: 8];

    uart_bit_tick #(
        .DIVISOR (DIVISOR)
    ) u_bit_tick (
        .i_clk     (high_clk_in),
        .i_reset   (reset),
        .i_enable  (enable),
        .i_restart (w_accept),
        .o_tick    (w_tick)
    );

    // Round-robin pick: scan from the farthest slot back to last_grant+1 so the nearest valid one wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_idx    = r_last_grant;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = 2'((int'(r_last_grant) + k) % N_REQ);
            if (w_valid4[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Offer a single-cycle ready to the winner, only while idle and running
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && enable && w_found;
        req_ready = w_accept ? (N_REQ'(1) << w_winner) : '0;
    end

    // Frame sequencer: latch on accept, then shift LSB-first on each bit tick
    always_ff @(posedge high_clk_in) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_tx         <= 1'b1;
            r_grant      <= 2'd0;
            r_last_grant <= 2'(N_REQ - 1);
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift      <= w_byte;
`ifdef UART_TX_PARITY_EN
                        r_parity     <= ^w_byte;
`endif
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_tx         <= 1'b0;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= 3'd0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            r_tx      <= r_parity;
                            r_state   <= ST_PARITY;
`else
                            r_tx      <= 1'b1;
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_out   = r_tx;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched at 10 clocks per bit (HIGH_CLK=1000, BAUD_CLK=100).
// Expected line levels come from a frame-level model: start 0, data LSB-first, [even parity], stop 1.
// Expected grants come from a round-robin model over the bench's own valid vector.
module tb_uart_tx_sched;

    localparam int N_REQ    = 2;
    localparam int BIT_CYC  = 10;
`ifdef UART_TX_PARITY_EN
    localparam int TB_BITS  = 11;
`else
    localparam int TB_BITS  = 10;
`endif
    localparam int FRAME_CYC = TB_BITS * BIT_CYC;
    localparam int WAIT_MAX  = 50;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b1;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [8*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_out;
    logic               busy;
    logic [1:0]         grant_id;

    int n_cmp;
    int n_bad;
    int m_last;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .HIGH_CLK (1000),
        .BAUD_CLK (100),
        .N_REQ    (N_REQ)
    ) dut (
        .high_clk_in (clk),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_out      (tx_out),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [N_REQ-1:0] mask, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (last + k) % N_REQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic model_level(input logic [7:0] b, input int bit_no);
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) return b[bit_no-1];
`ifdef UART_TX_PARITY_EN
        if (bit_no == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Wait for an accept, then check the whole frame cycle by cycle.
    task automatic run_frame(input string tag, input bit keep, input int exp_wait,
                             input int stall_at, input int stall_len, input int abort_at);
        int waited;
        int w;
        logic [7:0] b;
        logic [N_REQ-1:0] exp_rdy;
        logic lvl;
        waited = 0;
        #1;
        while (((req_ready & req_valid) == '0) && waited < WAIT_MAX) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk(32'(waited < WAIT_MAX), 32'(1), {tag, "_accept_timeout"});
        if (waited >= WAIT_MAX) return;
        w = model_winner(req_valid, m_last);
        if (w < 0) return;
        exp_rdy = '0;
        exp_rdy[w] = 1'b1;
        chk(32'(req_ready), 32'(exp_rdy), {tag, "_ready"});
        chk(32'(tx_out), 32'(1), {tag, "_idle_line"});
        if (exp_wait >= 0) chk(32'(waited), 32'(exp_wait), {tag, "_gap"});
        b = req_data[8*w +: 8];
        @(negedge clk);
        m_last = w;
        if (keep) req_data[8*w +: 8] = 8'($urandom);
        else req_valid[w] = 1'b0;
        chk(32'(grant_id), 32'(w), {tag, "_grant"});
        chk(32'(req_ready), 32'(0), {tag, "_ready_drop"});
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c == abort_at) return;
            lvl = model_level(b, c / BIT_CYC);
            chk(32'(tx_out), 32'(lvl), {tag, "_bit"});
            chk(32'(busy), 32'(1), {tag, "_busy"});
            if (c == stall_at) begin
                enable = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk(32'(tx_out), 32'(lvl), {tag, "_stall_hold"});
                    chk(32'(req_ready), 32'(0), {tag, "_stall_ready"});
                end
                enable = 1'b1;
            end
            @(negedge clk);
        end
        chk(32'(busy), 32'(0), {tag, "_end_busy"});
        chk(32'(tx_out), 32'(1), {tag, "_end_line"});
    endtask

    initial begin
        logic [N_REQ-1:0] mask;
        int st;
        n_cmp  = 0;
        n_bad  = 0;
        m_last = N_REQ - 1;

        // Reset then idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk(32'(tx_out), 32'(1), "idle_tx");
        chk(32'(busy), 32'(0), "idle_busy");
        chk(32'(req_ready), 32'(0), "idle_ready");
        chk(32'(grant_id), 32'(0), "idle_grant");

        // Single byte 0xA5 from requester 0
        req_data[7:0] = 8'hA5;
        req_valid = 2'b01;
        run_frame("a5", 1'b0, 0, -1, 0, -1);

        // Valid while disabled, then withdrawn: nothing is transferred
        enable = 1'b0;
        req_data[15:8] = 8'($urandom);
        req_valid = 2'b10;
        #1;
        chk(32'(req_ready), 32'(0), "dis_ready");
        repeat (3) @(negedge clk);
        chk(32'(req_ready), 32'(0), "dis_ready_hold");
        chk(32'(busy), 32'(0), "dis_busy");
        req_valid = 2'b00;
        enable = 1'b1;
        repeat (12) @(negedge clk);
        chk(32'(busy), 32'(0), "withdraw_busy");
        chk(32'(tx_out), 32'(1), "withdraw_tx");
        chk(32'(grant_id), 32'(0), "withdraw_grant");

        // Both requesters continuously valid: alternating grants, back-to-back frames
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_last = N_REQ - 1;
        req_data = {8'h22, 8'h11};
        req_valid = 2'b11;
        for (int f = 0; f < 4; f++) run_frame("b2b", 1'b1, 0, -1, 0, -1);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        // Reset 35 cycles into a frame from requester 1
        req_data[15:8] = 8'($urandom);
        req_valid = 2'b10;
        run_frame("rst", 1'b0, -1, -1, 0, 35);
        reset = 1'b1;
        @(negedge clk);
        chk(32'(tx_out), 32'(1), "rst_tx");
        chk(32'(busy), 32'(0), "rst_busy");
        chk(32'(grant_id), 32'(0), "rst_grant");
        reset = 1'b0;
        m_last = N_REQ - 1;
        req_data = 16'($urandom);
        req_valid = 2'b11;
        run_frame("post_rst0", 1'b0, 0, -1, 0, -1);
        run_frame("post_rst1", 1'b0, 0, -1, 0, -1);

        // enable low for 17 cycles in the middle of data bit 3
        req_data[7:0] = 8'($urandom);
        req_valid = 2'b01;
        run_frame("stall", 1'b0, -1, 45, 17, -1);

        // 0x07: parity bit 1 when parity is built in
        req_data[7:0] = 8'h07;
        req_valid = 2'b01;
        run_frame("p07", 1'b0, -1, -1, 0, -1);

        // Randomised request patterns, occasional stalls
        for (int f = 0; f < 10; f++) begin
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < N_REQ; i++)
                if (mask[i] && !req_valid[i]) req_data[8*i +: 8] = 8'($urandom);
            req_valid = mask;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME_CYC - 1)) : -1;
            run_frame("rnd", 1'($urandom_range(0, 1)), -1, st, int'($urandom_range(1, 20)), -1);
        end
        req_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
